// File: rtl/fpu_sched.sv
// FPU issue scheduler: dispatches one op per cycle to add/mul/div/sqrt/compare units
// and reserves writeback slots so the single result port never collides.
`timescale 1ns/1ps
module fpu_sched #(
  parameter int TAGW     = 5,
  parameter int LAT_ADD  = 3,
  parameter int LAT_MUL  = 2,
  parameter int LAT_DIV  = 10,
  parameter int LAT_SQRT = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [31:0]     req_a,
  input  logic [31:0]     req_b,
  input  logic [TAGW-1:0] req_tag,
  output logic [31:0]     u_a,
  output logic [31:0]     u_b,
  output logic [3:0]      u_start,
  input  logic [31:0]     res_add,
  input  logic [31:0]     res_mul,
  input  logic [31:0]     res_div,
  input  logic [31:0]     res_sqrt,
  input  logic            res_isneg,
  input  logic            res_iszero,
  input  logic            res_less,
  output logic            wb_valid,
  output logic [31:0]     wb_data,
  output logic [TAGW-1:0] wb_tag,
  output logic            busy
);

  localparam logic [2:0] SRC_ADD = 3'd0, SRC_MUL = 3'd1, SRC_DIV = 3'd2, SRC_SQRT = 3'd3,
                         SRC_NEG = 3'd4, SRC_ZERO = 3'd5, SRC_LESS = 3'd6;

  typedef struct packed {
    logic            vld;
    logic [2:0]      src;
    logic [TAGW-1:0] tag;
  } sb_ent_t;

  // sb_q[k] holds the op whose unit result is on the res_* bus k cycles from now
  sb_ent_t sb_q [16];
  sb_ent_t sb_d [16];

  logic [3:0]      div_cnt_q, div_cnt_d, sqrt_cnt_q, sqrt_cnt_d;
  logic            wb_valid_q;
  logic [31:0]     wb_data_q;
  logic [TAGW-1:0] wb_tag_q;

  logic [3:0]  lat;
  logic [2:0]  src;
  logic [3:0]  start;
  logic        acc;
  sb_ent_t     new_ent, head;
  logic [31:0] head_data;

  always_comb begin
    lat   = 4'd0;
    src   = SRC_ADD;
    start = 4'b0000;
    case (req_op)
      3'd0, 3'd1: begin lat = 4'(LAT_ADD);  src = SRC_ADD;  start = 4'b0001; end
      3'd2:       begin lat = 4'(LAT_MUL);  src = SRC_MUL;  start = 4'b0010; end
      3'd3:       begin lat = 4'(LAT_DIV);  src = SRC_DIV;  start = 4'b0100; end
      3'd4:       begin lat = 4'(LAT_SQRT); src = SRC_SQRT; start = 4'b1000; end
      3'd5:       src = SRC_NEG;
      3'd6:       src = SRC_ZERO;
      default:    src = SRC_LESS;
    endcase
  end

  assign req_ready = !sb_q[lat].vld
                   && !(start[2] && div_cnt_q != 4'd0)
                   && !(start[3] && sqrt_cnt_q != 4'd0);
  assign acc       = req_valid && req_ready;

  assign u_a     = req_a;
  assign u_b     = (req_op == 3'd1) ? {~req_b[31], req_b[30:0]} : req_b;
  assign u_start = acc ? start : 4'b0000;

  assign new_ent = '{vld: 1'b1, src: src, tag: req_tag};

  always_comb begin
    for (int k = 0; k < 15; k++) sb_d[k] = sb_q[k+1];
    sb_d[15] = '0;
    if (acc && lat != 4'd0) sb_d[lat - 4'd1] = new_ent;
  end

  // zero-latency ops bypass the scoreboard and claim the current slot directly
  assign head = (acc && lat == 4'd0) ? new_ent : sb_q[0];

  always_comb begin
    head_data = '0;
    case (head.src)
      SRC_ADD:  head_data = res_add;
      SRC_MUL:  head_data = res_mul;
      SRC_DIV:  head_data = res_div;
      SRC_SQRT: head_data = res_sqrt;
      SRC_NEG:  head_data = {31'b0, res_isneg};
      SRC_ZERO: head_data = {31'b0, res_iszero};
      SRC_LESS: head_data = {31'b0, res_less};
      default:  head_data = '0;
    endcase
  end

  always_comb begin
    div_cnt_d  = (div_cnt_q  != 4'd0) ? div_cnt_q  - 4'd1 : 4'd0;
    sqrt_cnt_d = (sqrt_cnt_q != 4'd0) ? sqrt_cnt_q - 4'd1 : 4'd0;
    if (acc && start[2]) div_cnt_d  = 4'(LAT_DIV);
    if (acc && start[3]) sqrt_cnt_d = 4'(LAT_SQRT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 16; k++) sb_q[k] <= '0;
      div_cnt_q  <= '0;
      sqrt_cnt_q <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_tag_q   <= '0;
    end else begin
      for (int k = 0; k < 16; k++) sb_q[k] <= sb_d[k];
      div_cnt_q  <= div_cnt_d;
      sqrt_cnt_q <= sqrt_cnt_d;
      wb_valid_q <= head.vld;
      if (head.vld) begin
        wb_data_q <= head_data;
        wb_tag_q  <= head.tag;
      end
    end
  end

  always_comb begin
    busy = (div_cnt_q != 4'd0) || (sqrt_cnt_q != 4'd0);
    for (int k = 0; k < 16; k++) busy = busy || sb_q[k].vld;
  end

  assign wb_valid = wb_valid_q;
  assign wb_data  = wb_data_q;
  assign wb_tag   = wb_tag_q;

endmodule
